// File: rtl/image_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : image_ram_loader
// Function : Loads one raster frame into the image RAM, then starts the
//            convolver and waits for its result burst to finish.
// Revision : 1.0
// ============================================================================
module image_ram_loader #(
  parameter int IMG_W        = 8,
  parameter int IMG_H        = 8,
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 6,
  parameter int START_LEN    = 2,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              conv_start,
  input  logic              conv_out_st,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                NPIX        = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam int                TMR_W       = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  C_TMO       = TMR_W'(WAIT_TIMEOUT);
  localparam int                SCNT_W      = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam logic [SCNT_W-1:0] C_SLAST     = SCNT_W'(START_LEN - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_RISE = 3'd3;
  localparam logic [2:0] S_WAIT_FALL = 3'd4;

  logic [2:0]        state_q,      state_d;
  logic [ADDR_W-1:0] pix_cnt_q,    pix_cnt_d;
  logic [TMR_W-1:0]  timer_q,      timer_d;
  logic [SCNT_W-1:0] scnt_q,       scnt_d;
  logic              ram_wr_q,     ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
  logic [DATA_W-1:0] ram_din_q,    ram_din_d;
  logic              conv_start_q, conv_start_d;
  logic              done_q,       done_d;
  logic              err_q,        err_d;
  logic              busy_q;

  logic              accept;
  logic              write_ok;
  logic [ADDR_W-1:0] frame_pos;
  logic [TMR_W-1:0]  timer_inc;
  logic              timeout;

  assign pix_ready = ~rst & ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign accept    = pix_valid & pix_ready;
  // A start-of-frame pixel always lands at address 0, in IDLE or as a restart in LOAD.
  assign frame_pos = pix_sof ? '0 : pix_cnt_q;
  assign write_ok  = accept & (pix_sof | (state_q == S_LOAD));
  assign timer_inc = (timer_q == C_TMO) ? C_TMO : timer_q + TMR_W'(1);
  assign timeout   = (timer_inc == C_TMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pix_cnt_q    <= '0;
      timer_q      <= '0;
      scnt_q       <= '0;
      ram_wr_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      conv_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      timer_q      <= timer_d;
      scnt_q       <= scnt_d;
      ram_wr_q     <= ram_wr_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      conv_start_q <= conv_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    timer_d   = timer_q;
    scnt_d    = scnt_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (write_ok) begin
          if (frame_pos == C_LAST_ADDR) begin
            state_d   = S_START;
            pix_cnt_d = '0;
          end else begin
            state_d   = S_LOAD;
            pix_cnt_d = frame_pos + ADDR_W'(1);
          end
        end
      end
      S_START: begin
        if (scnt_q == C_SLAST) begin
          scnt_d  = '0;
          timer_d = '0;
          state_d = S_WAIT_RISE;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      S_WAIT_RISE: begin
        if (conv_out_st) begin
          state_d = S_WAIT_FALL;
        end else if (timeout) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_WAIT_FALL: begin
        if (!conv_out_st) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the current state, so conv_start
  // trails the final RAM write by one cycle.
  always_comb begin
    ram_wr_d     = write_ok;
    ram_addr_d   = write_ok ? frame_pos : ram_addr_q;
    ram_din_d    = write_ok ? pix_data  : ram_din_q;
    conv_start_d = (state_q == S_START);
    done_d       = (state_q == S_WAIT_FALL) & ~conv_out_st;
    err_d        = (accept & ~write_ok)
                 | (accept & pix_sof & (state_q == S_LOAD))
                 | ((state_q == S_WAIT_RISE) & ~conv_out_st & timeout);
  end

  assign ram_wr     = ram_wr_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign conv_start = conv_start_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_image_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_ram_loader
// Function : Randomised frame traffic against a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_image_ram_loader;

  localparam int IMG_W        = 8;
  localparam int IMG_H        = 8;
  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 6;
  localparam int START_LEN    = 2;
  localparam int WAIT_TIMEOUT = 1024;
  localparam int NPIX         = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pix_valid = 1'b0;
  logic              pix_sof = 1'b0;
  logic [DATA_W-1:0] pix_data = '0;
  logic              conv_out_st = 1'b0;
  logic              pix_ready, ram_wr, conv_start, busy, done, err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;

  image_ram_loader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .START_LEN(START_LEN), .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready), .ram_wr(ram_wr),
    .ram_addr(ram_addr), .ram_din(ram_din), .conv_start(conv_start),
    .conv_out_st(conv_out_st), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, pcyc);
    end
  endtask

  // Behavioural model: frame position plus "cycles since last write of the frame".
  int m_next, m_run;
  bit m_inframe, m_risen;
  bit e_wr, e_err, e_done, e_cs, e_busy, e_ready;
  int e_addr, e_din;

  task automatic model_reset();
    m_next = 0; m_run = -1; m_inframe = 0; m_risen = 0;
    e_wr = 0; e_err = 0; e_done = 0; e_cs = 0; e_busy = 0; e_ready = 1;
    e_addr = 0; e_din = 0;
  endtask

  task automatic model_step();
    bit ready;
    int pos;
    ready = (m_run < 0);
    e_wr = 0; e_err = 0; e_done = 0;
    if (m_run >= 0) begin
      m_run++;
      if (m_run > START_LEN) begin
        if (!m_risen) begin
          if (conv_out_st) m_risen = 1;
          else if (m_run - START_LEN == WAIT_TIMEOUT) begin
            e_err = 1; m_run = -1;
          end
        end else if (!conv_out_st) begin
          e_done = 1; m_run = -1; m_risen = 0;
        end
      end
    end
    if (ready && pix_valid) begin
      pos = -1;
      if (pix_sof) begin
        if (m_inframe) e_err = 1;
        pos = 0;
      end else if (!m_inframe) e_err = 1;
      else pos = m_next;
      if (pos >= 0) begin
        e_wr = 1; e_addr = pos; e_din = int'(pix_data);
        if (pos == NPIX - 1) begin
          m_inframe = 0; m_next = 0; m_run = 0;
        end else begin
          m_inframe = 1; m_next = pos + 1;
        end
      end
    end
    e_cs    = (m_run >= 1) && (m_run <= START_LEN);
    e_ready = (m_run < 0);
    e_busy  = (m_run >= 0) || m_inframe;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Observation records used by the literal checks.
  int wr_cnt, err_cnt, done_cnt, cs_cnt;
  int first_wr_cyc, last_wr_cyc, cs_rise_cyc, done_cyc, err_cyc, fall_cyc;
  int first_addr, last_addr, last_din;
  bit cs_prev = 0;
  bit conv_en = 1;
  bit conv_prev = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("pix_ready", pix_ready, e_ready);
        check("ram_wr", ram_wr, e_wr);
        if (e_wr) begin
          check("ram_addr", ram_addr, e_addr);
          check("ram_din", ram_din, e_din);
        end
        check("conv_start", conv_start, e_cs);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("err", err, e_err);
        if (ram_wr) begin
          wr_cnt++;
          if (wr_cnt == 1) begin first_wr_cyc = pcyc; first_addr = int'(ram_addr); end
          last_wr_cyc = pcyc; last_addr = int'(ram_addr); last_din = int'(ram_din);
        end
        if (conv_start && !cs_prev) cs_rise_cyc = pcyc;
        if (conv_start) cs_cnt++;
        cs_prev = conv_start;
        if (done) begin done_cnt++; done_cyc = pcyc; end
        if (err) begin err_cnt++; err_cyc = pcyc; end
      end
    end
  end

  // Convolver stand-in: result burst starts 5 cycles after conv_start falls.
  initial begin
    forever begin
      @(negedge clk);
      if (conv_en && conv_prev && !conv_start && !rst) begin
        repeat (5) @(negedge clk);
        conv_out_st = 1'b1;
        repeat (36) @(negedge clk);
        conv_out_st = 1'b0;
        fall_cyc = pcyc;
      end
      conv_prev = conv_start;
    end
  end

  task automatic clear_obs();
    #1;
    wr_cnt = 0; err_cnt = 0; done_cnt = 0; cs_cnt = 0;
    first_addr = -1; last_addr = -1; last_din = -1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit sof, input int gap);
    int n;
    bit ok;
    n = 0; ok = 0;
    while (!ok) begin
      @(negedge clk);
      pix_data  = d;
      pix_sof   = sof;
      pix_valid = ($urandom_range(99) >= gap);
      if (pix_valid && pix_ready) ok = 1;
      else begin
        n++;
        if (n > 200) begin
          checks++; errors++;
          $display("FAIL send_timeout: pixel not accepted in %0d cycles, need acceptance", n);
          ok = 1;
        end
      end
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = DATA_W'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done_cnt == 0 && n < limit) begin @(negedge clk); n++; end
    #1;
    if (done_cnt == 0) begin
      checks++; errors++;
      $display("FAIL wait_done: no done pulse in %0d cycles, need one", limit);
    end
  endtask

  task automatic wait_err(input int limit);
    int n;
    n = 0;
    while (err_cnt == 0 && n < limit) begin @(negedge clk); n++; end
    #1;
    if (err_cnt == 0) begin
      checks++; errors++;
      $display("FAIL wait_err: no err pulse in %0d cycles, need one", limit);
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit, need completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_conv_start", conv_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", pix_ready, 1);

    // Full-rate frame 0..63.
    clear_obs();
    for (int i = 0; i < NPIX; i++) send(DATA_W'(i), (i == 0), 0);
    idle_in();
    wait_done(400);
    check("t1_wr_count", wr_cnt, 64);
    check("t1_wr_consecutive", last_wr_cyc - first_wr_cyc, 63);
    check("t1_last_din", last_din, 63);
    check("t1_cs_after_wr", cs_rise_cyc - last_wr_cyc, 1);
    check("t1_cs_len", cs_cnt, 2);
    check("t1_done_lat", done_cyc - fall_cyc, 1);
    check("t1_err_cnt", err_cnt, 0);

    // 50% valid gaps, descending data.
    clear_obs();
    for (int i = 0; i < NPIX; i++) send(DATA_W'(8'hFF - i), (i == 0), 50);
    idle_in();
    wait_done(1000);
    check("t2_wr_count", wr_cnt, 64);
    check("t2_first_addr", first_addr, 0);
    check("t2_last_addr", last_addr, 63);
    check("t2_last_din", last_din, 8'hC0);
    check("t2_err_cnt", err_cnt, 0);

    // Restart via sof on pixel 20.
    clear_obs();
    for (int i = 0; i < 20; i++) send(DATA_W'(i), (i == 0), 20);
    send(8'hA5, 1'b1, 20);
    for (int i = 1; i < NPIX; i++) send(DATA_W'(100 + i), 1'b0, 20);
    idle_in();
    wait_done(800);
    check("t3_wr_count", wr_cnt, 84);
    check("t3_err_cnt", err_cnt, 1);
    check("t3_last_addr", last_addr, 63);
    check("t3_last_din", last_din, 163);

    // Stray pixel while idle.
    clear_obs();
    send(8'h55, 1'b0, 0);
    idle_in();
    repeat (2) @(negedge clk);
    #1;
    check("t4_dropped_wr", wr_cnt, 0);
    check("t4_err_cnt", err_cnt, 1);
    check("t4_busy", busy, 0);
    clear_obs();
    for (int i = 0; i < NPIX; i++) send(DATA_W'(i ^ 8'h3C), (i == 0), 30);
    idle_in();
    wait_done(800);
    check("t4_first_addr", first_addr, 0);
    check("t4_wr_count", wr_cnt, 64);

    // Convolver never answers.
    conv_en = 0;
    clear_obs();
    for (int i = 0; i < NPIX; i++) send(DATA_W'($urandom), (i == 0), 25);
    idle_in();
    wait_err(WAIT_TIMEOUT + 100);
    check("t6_timeout_lat", err_cyc - last_wr_cyc, START_LEN + WAIT_TIMEOUT);
    check("t6_done_cnt", done_cnt, 0);
    @(negedge clk);
    #1;
    check("t6_ready", pix_ready, 1);
    check("t6_busy", busy, 0);
    conv_en = 1;

    // Asynchronous reset while pixel 30 is presented.
    clear_obs();
    for (int i = 0; i < 30; i++) send(DATA_W'(i + 7), (i == 0), 0);
    @(negedge clk);
    pix_data = 8'd37; pix_sof = 1'b0; pix_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t7_rst_ready", pix_ready, 0);
    check("t7_rst_wr", ram_wr, 0);
    check("t7_rst_addr", ram_addr, 0);
    check("t7_rst_din", ram_din, 0);
    check("t7_rst_cs", conv_start, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_done", done, 0);
    check("t7_rst_err", err, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    rst = 1'b0;
    clear_obs();
    for (int i = 0; i < NPIX; i++) send(DATA_W'(i + 1), (i == 0), 10);
    idle_in();
    wait_done(600);
    check("t7_first_addr", first_addr, 0);
    check("t7_wr_count", wr_cnt, 64);
    check("t7_err_cnt", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
